// File: rtl/fifo_stream_drain.sv
// Read-side drain stage: pops words from a synchronous FIFO and presents them
// as a valid/ready stream through a 2-entry skid buffer, tagging burst ends.
module fifo_stream_drain #(
    parameter int WIDTH     = 32,
    parameter int BURST_LEN = 16
) (
    input  logic             i_clk,
    input  logic             arst_n,
    input  logic             i_clr,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic [15:0]      o_beat_cnt
);

    localparam logic [15:0] LAST_BEAT = 16'(BURST_LEN - 1);

    logic [1:0][WIDTH-1:0] buf_data;
    logic [1:0]            buf_last;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            occ;
    logic                  inflight;
    logic [15:0]           cap_cnt;
    logic [15:0]           beat_cnt;

    logic                  transfer;
    logic                  capture;
    logic                  cap_last;
    logic [2:0]            fill;
    logic [2:0]            room;

    assign transfer = m_valid && m_ready;
    assign capture  = inflight;

    // cap_cnt runs ahead of beat_cnt by the number of buffered words, so the
    // last flag can be stamped on a word the moment it enters the buffer.
    assign cap_last = (cap_cnt == LAST_BEAT);

    // Credit is positive when occupancy plus the in-flight word leaves room,
    // counting the slot freed by a transfer this cycle.
    assign fill       = {1'b0, occ} + {2'b00, inflight};
    assign room       = 3'd2 + {2'b00, transfer};
    assign fifo_rd_en = arst_n && !i_clr && !fifo_empty && (fill < room);

    assign m_valid    = (occ != 2'd0);
    assign m_data     = buf_data[rd_ptr];
    assign m_last     = buf_last[rd_ptr];
    assign o_beat_cnt = beat_cnt;

    always_ff @(posedge i_clk or negedge arst_n) begin
        if (!arst_n) begin
            buf_data <= '0;
            buf_last <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            occ      <= 2'd0;
            inflight <= 1'b0;
            cap_cnt  <= 16'd0;
            beat_cnt <= 16'd0;
        end else if (i_clr) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            occ      <= 2'd0;
            inflight <= 1'b0;
            cap_cnt  <= 16'd0;
            beat_cnt <= 16'd0;
        end else begin
            inflight <= fifo_rd_en;
            if (capture) begin
                buf_data[wr_ptr] <= fifo_rd_data;
                buf_last[wr_ptr] <= cap_last;
                wr_ptr           <= ~wr_ptr;
                cap_cnt          <= cap_last ? 16'd0 : cap_cnt + 16'd1;
            end
            if (transfer) begin
                rd_ptr   <= ~rd_ptr;
                beat_cnt <= (beat_cnt == LAST_BEAT) ? 16'd0 : beat_cnt + 16'd1;
            end
            case ({capture, transfer})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // A capture into a full buffer with no transfer would overflow; the credit
    // rule makes that unreachable.
    always_ff @(posedge i_clk) begin
        if (arst_n && !i_clr) begin
            assert (!(capture && !transfer && occ == 2'd2));
        end
    end

endmodule
